regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file; next generation of the single-cycle core's regfile.
//   Provides NRD combinational read ports and two write ports with fixed priority.
//   Optional hardwired-zero register and optional write-to-read bypass.
//   Sequential clear engine zeroes the array after reset or on request, one entry per cycle.
//   Sits between decode (read addresses) and writeback (write ports) of the datapath.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   address width; NUM_REGS = 2**ADDR_W entries
//   NRD       2   number of read ports, 1..4
//   ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
//   BYPASS    1   1: same-cycle write data is forwarded to matching reads; 0: reads return stored value
// PORTS
//   clk      in   1            rising-edge clock
//   reset_n  in   1            asynchronous, active-low reset
//   clr_req  in   1            single-cycle pulse; starts a full clear when idle
//   busy     out  1            1 while the clear engine runs
//   we0      in   1            write enable, port 0
//   waddr0   in   ADDR_W       write address, port 0
//   wdata0   in   DATA_W       write data, port 0
//   we1      in   1            write enable, port 1 (higher priority)
//   waddr1   in   ADDR_W       write address, port 1
//   wdata1   in   DATA_W       write data, port 1
//   raddr    in   NRD*ADDR_W   packed read addresses; port i = raddr[i*ADDR_W +: ADDR_W]
//   rdata    out  NRD*DATA_W   packed read data; port i = rdata[i*DATA_W +: DATA_W]
// BEHAVIOUR
//   - FSM states: CLEAR, IDLE. Clear counter clr_cnt is ADDR_W bits.
//   - Reset: reset_n low forces state=CLEAR and clr_cnt=0 asynchronously. busy=1 and all rdata=0 while in reset.
//     The storage array itself has no reset.
//   - CLEAR: each clk writes 0 to entry clr_cnt and increments clr_cnt.
//     When clr_cnt==NUM_REGS-1, that last entry is cleared and the FSM goes to IDLE next cycle.
//     A full clear takes exactly NUM_REGS cycles. busy is asserted for all of them.
//   - While busy=1:
//     - write ports are ignored;
//     - clr_req is ignored (no restart);
//     - every rdata is 0.
//   - IDLE: busy=0.
//     - clr_req=1 moves the FSM to CLEAR with clr_cnt=0.
//     - Writes presented in the same cycle as clr_req are dropped.
//   - Reset mid-clear: the clear restarts from clr_cnt=0.
//   - Writes (IDLE only) commit on the rising edge; they are visible in stored reads from the next cycle.
//   - we0 and we1 to the same address in one cycle: wdata1 is stored; port 0's write is dropped.
//   - ZERO_REG=1: writes to address 0 are discarded, and any read of address 0 returns 0, including via bypass.
//   - Reads are combinational with zero latency. Each port's read value, in priority order:
//     - busy: 0;
//     - ZERO_REG && addr==0: 0;
//     - BYPASS && we1 && waddr1==addr: wdata1;
//     - BYPASS && we0 && waddr0==addr: wdata0;
//     - otherwise: the stored entry.
//   - Read ports are independent. Any number of ports may read the same address.
//   - No arithmetic on data. Addresses are used at full ADDR_W width with no wrap/aliasing.
// TESTING
//   1. Release reset_n: busy=1 for exactly 32 cycles, then 0. Read of every address afterwards returns 0.
//   2. we0=1, waddr0=5, wdata0=0xDEADBEEF, raddr port0=5, same cycle:
//      - BYPASS=1: rdata0=0xDEADBEEF that cycle;
//      - BYPASS=0: rdata0=0 that cycle and 0xDEADBEEF the next.
//   3. we0/we1 both to addr 7 with 0x11111111 / 0x22222222: later read of 7 = 0x22222222.
//      Same write pair to addr 0 with ZERO_REG=1: read of 0 = 0.
//   4. Load regs 1..31 with distinct values, pulse clr_req while we0 writes 0xAAAA to addr 3:
//      - busy=1 for 32 cycles;
//      - writes during that window are dropped;
//      - all reads return 0 throughout and afterwards.
//   5. Assert reset_n=0 at clear cycle 10 for 2 cycles: busy stays 1 and the clear lasts a full 32 cycles after release.
//   6. NRD=4: all four ports read distinct addresses plus one duplicate in one cycle. Each returns its correct stored value.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register file port bundle: clear control, two write ports and
// packed read ports, seen from the datapath (master) and the array (slave).
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                    clr_req;
    logic                    busy;
    logic                    we0;
    logic [ADDR_W-1:0]       waddr0;
    logic [DATA_W-1:0]       wdata0;
    logic                    we1;
    logic [ADDR_W-1:0]       waddr1;
    logic [DATA_W-1:0]       wdata1;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*DATA_W-1:0]   rdata;

    modport master (
        output clr_req, we0, waddr0, wdata0,
        output we1, waddr1, wdata1, raddr,
        input  busy, rdata
    );

    modport slave (
        input  clr_req, we0, waddr0, wdata0,
        input  we1, waddr1, wdata1, raddr,
        output busy, rdata
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports,
// combinational read ports, optional zero register/bypass, clear engine.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    regfile_mp_if.slave   bus
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              busy;
    logic              wr_ok;
    logic              wr0;
    logic              wr1;
    logic              z0;
    logic              z1;

    assign busy     = (state == CLEAR);
    assign bus.busy = busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST)
                        state <= IDLE;
                end
                IDLE: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // A clear request swallows the writes of its own cycle
    assign wr_ok = (state == IDLE) && !bus.clr_req;
    assign z0    = (ZERO_REG != 0) && (bus.waddr0 == '0);
    assign z1    = (ZERO_REG != 0) && (bus.waddr1 == '0);
    assign wr1   = wr_ok && bus.we1 && !z1;
    assign wr0   = wr_ok && bus.we0 && !z0 &&
                   !(bus.we1 && (bus.waddr1 == bus.waddr0));

    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_cnt] <= '0;
        if (wr0)
            mem[bus.waddr0] <= bus.wdata0;
        if (wr1)
            mem[bus.waddr1] <= bus.wdata1;
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;

        assign a = bus.raddr[g*ADDR_W +: ADDR_W];

        always_comb begin
            v = mem[a];
            if (busy)
                v = '0;
            else if ((ZERO_REG != 0) && (a == '0))
                v = '0;
            else if ((BYPASS != 0) && bus.we1 && (bus.waddr1 == a))
                v = bus.wdata1;
            else if ((BYPASS != 0) && bus.we0 && (bus.waddr0 == a))
                v = bus.wdata0;
        end

        assign bus.rdata[g*DATA_W +: DATA_W] = v;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register file builds (zero-reg+bypass, 4 reads;
// plain, 2 reads) driven together and checked against an array model.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(4)) bus_a ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus_b ();

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NRD(4), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    typedef struct packed {
        logic             busy;
        logic [3:0][31:0] ra;
        logic [1:0][31:0] rb;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    int          busy_left = 32;
    int          errors = 0;
    int          checks = 0;
    bit          done = 0;

    function automatic logic [31:0] model_rd(
        input bit z, input bit byp, input bit bsy,
        input logic [31:0] stored, input logic [4:0] a,
        input logic w0, input logic [4:0] a0, input logic [31:0] d0,
        input logic w1, input logic [4:0] a1, input logic [31:0] d1);
        if (bsy) return 32'h0;
        if (z && a == 5'd0) return 32'h0;
        if (byp && w1 && a1 == a) return d1;
        if (byp && w0 && a0 == a) return d0;
        return stored;
    endfunction

    task automatic cycle(
        input logic rst, input logic clr,
        input logic w0, input logic [4:0] a0, input logic [31:0] d0,
        input logic w1, input logic [4:0] a1, input logic [31:0] d1,
        input logic [19:0] ra);
        exp_t e;
        bit   bsy;
        logic [4:0] a;
        @(posedge clk);
        #1;
        reset_n = rst;
        bus_a.clr_req = clr; bus_b.clr_req = clr;
        bus_a.we0 = w0; bus_a.waddr0 = a0; bus_a.wdata0 = d0;
        bus_b.we0 = w0; bus_b.waddr0 = a0; bus_b.wdata0 = d0;
        bus_a.we1 = w1; bus_a.waddr1 = a1; bus_a.wdata1 = d1;
        bus_b.we1 = w1; bus_b.waddr1 = a1; bus_b.wdata1 = d1;
        bus_a.raddr = ra;
        bus_b.raddr = ra[9:0];
        bsy = !rst || busy_left > 0;
        e.busy = bsy;
        for (int i = 0; i < 4; i++) begin
            a = ra[i*5 +: 5];
            e.ra[i] = model_rd(1, 1, bsy, mem_a[a], a,
                               w0, a0, d0, w1, a1, d1);
        end
        for (int i = 0; i < 2; i++) begin
            a = ra[i*5 +: 5];
            e.rb[i] = model_rd(0, 0, bsy, mem_b[a], a,
                               w0, a0, d0, w1, a1, d1);
        end
        q.push_back(e);
        // Whole array reads as zero once any clear completes
        if (!rst || (busy_left == 0 && clr)) begin
            busy_left = 32;
            for (int i = 0; i < 32; i++) begin
                mem_a[i] = 32'h0;
                mem_b[i] = 32'h0;
            end
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (w0 && a0 != 5'd0) mem_a[a0] = d0;
            if (w1 && a1 != 5'd0) mem_a[a1] = d1;
            if (w0) mem_b[a0] = d0;
            if (w1) mem_b[a1] = d1;
        end
    endtask

    task automatic idle(input logic [19:0] ra);
        cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ra);
    endtask

    task automatic sweep();
        for (int k = 0; k < 8; k++)
            idle({5'(4*k+3), 5'(4*k+2), 5'(4*k+1), 5'(4*k)});
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("busy_a", 32'(bus_a.busy), 32'(e.busy));
            chk("busy_b", 32'(bus_b.busy), 32'(e.busy));
            for (int i = 0; i < 4; i++)
                chk($sformatf("rdata_a%0d", i),
                    bus_a.rdata[i*32 +: 32], e.ra[i]);
            for (int i = 0; i < 2; i++)
                chk($sformatf("rdata_b%0d", i),
                    bus_b.rdata[i*32 +: 32], e.rb[i]);
        end
    end

    function automatic logic [4:0] raddr_rand();
        if ($urandom_range(0, 1) == 0)
            return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        bus_a.clr_req = 0; bus_b.clr_req = 0;
        bus_a.we0 = 0; bus_a.waddr0 = 0; bus_a.wdata0 = 0;
        bus_a.we1 = 0; bus_a.waddr1 = 0; bus_a.wdata1 = 0;
        bus_b.we0 = 0; bus_b.waddr0 = 0; bus_b.wdata0 = 0;
        bus_b.we1 = 0; bus_b.waddr1 = 0; bus_b.wdata1 = 0;
        bus_a.raddr = 0; bus_b.raddr = 0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        #1 reset_n = 1'b0;

        repeat (3)
            cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 20'h0);
        repeat (33) idle({5'd3, 5'd2, 5'd1, 5'd0});
        sweep();

        cycle(1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,
              {5'd0, 5'd0, 5'd6, 5'd5});
        idle({5'd0, 5'd0, 5'd6, 5'd5});

        cycle(1, 0, 1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222,
              {5'd7, 5'd0, 5'd0, 5'd7});
        cycle(1, 0, 1, 5'd0, 32'h11111111, 1, 5'd0, 32'h22222222,
              {5'd0, 5'd7, 5'd7, 5'd0});
        idle({5'd5, 5'd0, 5'd0, 5'd7});

        for (int i = 1; i < 32; i++)
            cycle(1, 0, 1, 5'(i), 32'hA5000000 | 32'(i * 4099),
                  0, 5'd0, 32'h0, {5'(i), 5'(i - 1), 5'd3, 5'(i)});
        sweep();
        cycle(1, 1, 1, 5'd3, 32'h0000AAAA, 0, 5'd0, 32'h0,
              {5'd1, 5'd2, 5'd4, 5'd3});
        for (int i = 0; i < 32; i++)
            cycle(1, 0, 1, raddr_rand(), $urandom(),
                  1, raddr_rand(), $urandom(), 20'($urandom()));
        sweep();

        cycle(1, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 20'h0);
        repeat (10) idle(20'($urandom()));
        repeat (2) cycle(0, 0, 1, 5'd4, 32'h1234, 0, 5'd0, 32'h0,
                         {5'd4, 5'd4, 5'd4, 5'd4});
        repeat (33) idle({5'd1, 5'd2, 5'd3, 5'd4});

        cycle(1, 0, 1, 5'd9, 32'h99999999, 1, 5'd10, 32'hAAAA0000, 20'h0);
        cycle(1, 0, 1, 5'd11, 32'hBBBB1111, 0, 5'd0, 32'h0, 20'h0);
        idle({5'd9, 5'd11, 5'd10, 5'd9});

        for (int n = 0; n < 800; n++) begin
            cycle(1, ($urandom_range(0, 99) == 0),
                  1'($urandom()), raddr_rand(), $urandom(),
                  1'($urandom()), raddr_rand(), $urandom(),
                  {raddr_rand(), raddr_rand(), raddr_rand(), raddr_rand()});
        end
        idle(20'h0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        done = 1;
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout got=running expected=finished");
            $fatal(1, "timeout");
        end
    end
endmodule
